// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with a two-entry skid buffer.
// All state updates on the falling edge of clk. The head entry drives the
// *_store outputs and the writeback signals. A skid entry absorbs one extra
// input so that in_ready depends only on registered state.
module mem_wb_pipe #(
   parameter int DATA_W = 64,
   parameter int RD_W   = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              RegWrite,
   input  logic              MemtoReg,
   input  logic [DATA_W-1:0] ReadData,
   input  logic [DATA_W-1:0] ALU_result,
   input  logic [RD_W-1:0]   rd,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              RegWrite_store,
   output logic              MemtoReg_store,
   output logic [DATA_W-1:0] ReadData_store,
   output logic [DATA_W-1:0] ALU_result_store,
   output logic [RD_W-1:0]   rd_store,
   output logic              wb_we,
   output logic [DATA_W-1:0] wb_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int PAY_W = 2 + 2*DATA_W + RD_W;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [PAY_W-1:0] in_pay;
   logic [PAY_W-1:0] head_pay;
   logic [PAY_W-1:0] skid_pay;
   logic             accept;
   logic             transfer;
   logic             load_head_in;
   logic             load_head_skid;
   logic             load_skid;

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}})
         sat_inc = v;
      else
         sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign in_pay    = {RegWrite, MemtoReg, ReadData, ALU_result, rd};
   assign in_ready  = (state != TWO);
   assign out_valid = (state != EMPTY);
   assign accept    = in_valid && in_ready;
   assign transfer  = out_valid && out_ready;

   assign RegWrite_store   = head_pay[PAY_W-1];
   assign MemtoReg_store   = head_pay[PAY_W-2];
   assign ReadData_store   = head_pay[RD_W+2*DATA_W-1 -: DATA_W];
   assign ALU_result_store = head_pay[RD_W+DATA_W-1 -: DATA_W];
   assign rd_store         = head_pay[RD_W-1:0];

   // Register x0 is hardwired to zero, so writes to it are suppressed.
   assign wb_we   = out_valid && RegWrite_store && (rd_store != '0);
   assign wb_data = MemtoReg_store ? ReadData_store : ALU_result_store;

   // Next-state and payload-move decode; flush overrides to EMPTY.
   always_comb begin
      state_nxt      = state;
      load_head_in   = 1'b0;
      load_head_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               load_head_in = 1'b1;
               state_nxt    = ONE;
            end
         end
         ONE: begin
            if (accept && transfer) begin
               load_head_in = 1'b1;
            end else if (accept) begin
               load_skid = 1'b1;
               state_nxt = TWO;
            end else if (transfer) begin
               state_nxt = EMPTY;
            end
         end
         TWO: begin
            if (transfer) begin
               load_head_skid = 1'b1;
               state_nxt      = ONE;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      if (flush)
         state_nxt = EMPTY;
   end

   // State register; reset dominates flush and handshakes.
   always_ff @(negedge clk) begin
      if (!reset)
         state <= EMPTY;
      else
         state <= state_nxt;
   end

   // Head/skid payload; a flushed edge leaves payload untouched (it is dead).
   always_ff @(negedge clk) begin
      if (!reset) begin
         head_pay <= '0;
         skid_pay <= '0;
      end else if (!flush) begin
         if (load_head_in)
            head_pay <= in_pay;
         else if (load_head_skid)
            head_pay <= skid_pay;
         if (load_skid)
            skid_pay <= in_pay;
      end
   end

   // Count cycles where upstream offers data but is refused.
   always_ff @(negedge clk) begin
      if (!reset)
         stall_cnt <= '0;
      else if (in_valid && !in_ready && !flush)
         stall_cnt <= sat_inc(stall_cnt);
   end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed testbench for mem_wb_pipe; a second instance with CNT_W=2
// exercises stall counter saturation.
module tb_mem_wb_pipe;

   localparam int DATA_W = 64;
   localparam int RD_W   = 5;
   localparam int CNT_W  = 16;

   logic              clk;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic              RegWrite;
   logic              MemtoReg;
   logic [DATA_W-1:0] ReadData;
   logic [DATA_W-1:0] ALU_result;
   logic [RD_W-1:0]   rd;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic              RegWrite_store;
   logic              MemtoReg_store;
   logic [DATA_W-1:0] ReadData_store;
   logic [DATA_W-1:0] ALU_result_store;
   logic [RD_W-1:0]   rd_store;
   logic              wb_we;
   logic [DATA_W-1:0] wb_data;
   logic [CNT_W-1:0]  stall_cnt;

   logic              in_ready2;
   logic              out_valid2;
   logic              RegWrite_store2;
   logic              MemtoReg_store2;
   logic [DATA_W-1:0] ReadData_store2;
   logic [DATA_W-1:0] ALU_result_store2;
   logic [RD_W-1:0]   rd_store2;
   logic              wb_we2;
   logic [DATA_W-1:0] wb_data2;
   logic [1:0]        stall_cnt2;

   int n_cmp;
   int n_fail;

   mem_wb_pipe #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ReadData(ReadData),
      .ALU_result(ALU_result), .rd(rd), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .RegWrite_store(RegWrite_store), .MemtoReg_store(MemtoReg_store),
      .ReadData_store(ReadData_store), .ALU_result_store(ALU_result_store),
      .rd_store(rd_store), .wb_we(wb_we), .wb_data(wb_data),
      .stall_cnt(stall_cnt)
   );

   mem_wb_pipe #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
      .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ReadData(ReadData),
      .ALU_result(ALU_result), .rd(rd), .flush(flush),
      .out_valid(out_valid2), .out_ready(out_ready),
      .RegWrite_store(RegWrite_store2), .MemtoReg_store(MemtoReg_store2),
      .ReadData_store(ReadData_store2), .ALU_result_store(ALU_result_store2),
      .rd_store(rd_store2), .wb_we(wb_we2), .wb_data(wb_data2),
      .stall_cnt(stall_cnt2)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   // One active (falling) edge, then settle before sampling.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic rw, input logic m2r,
                        input logic [DATA_W-1:0] rdat, input logic [DATA_W-1:0] alu,
                        input logic [RD_W-1:0] r);
      in_valid   = v;
      RegWrite   = rw;
      MemtoReg   = m2r;
      ReadData   = rdat;
      ALU_result = alu;
      rd         = r;
   endtask

   task automatic test_reset();
      reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 64'h1234, 64'h5678, 5'd9);
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
      n_cmp++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt got=%0h exp=0", stall_cnt); end
      n_cmp++; if ({RegWrite_store, MemtoReg_store, rd_store} !== 7'd0) begin n_fail++; $display("FAIL reset_ctrl_store got=%0h exp=0", {RegWrite_store, MemtoReg_store, rd_store}); end
      n_cmp++; if (ReadData_store !== 64'd0 || ALU_result_store !== 64'd0) begin n_fail++; $display("FAIL reset_data_store got=%0h/%0h exp=0/0", ReadData_store, ALU_result_store); end
      n_cmp++; if (wb_we !== 1'b0 || wb_data !== 64'd0) begin n_fail++; $display("FAIL reset_wb got=%0h/%0h exp=0/0", wb_we, wb_data); end
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got=%0h exp=0", out_valid); end
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 1'b1, 1'b0, 64'd0, 64'(i), 5'(i));
         n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got=%0h exp=1", i, in_ready); end
         tick();
         n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_out_valid[%0d] got=%0h exp=1", i, out_valid); end
         n_cmp++; if (wb_data !== 64'(i)) begin n_fail++; $display("FAIL stream_wb_data[%0d] got=%0h exp=%0h", i, wb_data, i); end
         n_cmp++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL stream_wb_we[%0d] got=%0h exp=1", i, wb_we); end
      end
      drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got=%0h exp=0", out_valid); end
      n_cmp++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL stream_stall_cnt got=%0h exp=0", stall_cnt); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 64'd0, 64'hA, 5'd1);
      tick();
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one got=%0h exp=1", in_ready); end
      drive(1'b1, 1'b1, 1'b0, 64'd0, 64'hB, 5'd2);
      tick();
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_two got=%0h exp=0", in_ready); end
      drive(1'b1, 1'b1, 1'b0, 64'd0, 64'hC, 5'd3);
      for (int k = 1; k <= 3; k++) begin
         tick();
         n_cmp++; if (stall_cnt !== 16'(k)) begin n_fail++; $display("FAIL bp_stall_cnt[%0d] got=%0h exp=%0h", k, stall_cnt, k); end
         n_cmp++; if (wb_data !== 64'hA) begin n_fail++; $display("FAIL bp_head_stable[%0d] got=%0h exp=a", k, wb_data); end
      end
      out_ready = 1'b1;
      tick();
      n_cmp++; if (wb_data !== 64'hB) begin n_fail++; $display("FAIL bp_order_b got=%0h exp=b", wb_data); end
      n_cmp++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL bp_stall_release got=%0h exp=4", stall_cnt); end
      tick();
      n_cmp++; if (wb_data !== 64'hC || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_order_c got=%0h/%0h exp=c/1", wb_data, out_valid); end
      drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%0h exp=0", out_valid); end
      n_cmp++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL bp_stall_final got=%0h exp=4", stall_cnt); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 64'd0, 64'h11, 5'd4);
      tick();
      drive(1'b1, 1'b1, 1'b0, 64'd0, 64'h22, 5'd5);
      tick();
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_pre_two got=%0h exp=0", in_ready); end
      drive(1'b1, 1'b1, 1'b0, 64'd0, 64'h33, 5'd6);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%0h exp=0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got=%0h exp=1", in_ready); end
      n_cmp++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL flush_stall_cnt got=%0h exp=4", stall_cnt); end
      drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
      out_ready = 1'b1;
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_ghost got=%0h exp=0", out_valid); end
      drive(1'b1, 1'b1, 1'b0, 64'd0, 64'h44, 5'd7);
      tick();
      n_cmp++; if (wb_data !== 64'h44 || out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_resume got=%0h/%0h exp=44/1", wb_data, out_valid); end
      drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
      tick();
   endtask

   task automatic test_wb_select();
      out_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 64'hDEAD, 64'hBEEF, 5'd3);
      tick();
      n_cmp++; if (wb_data !== 64'hDEAD) begin n_fail++; $display("FAIL wb_sel_mem got=%0h exp=dead", wb_data); end
      n_cmp++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL wb_we_rd3 got=%0h exp=1", wb_we); end
      out_ready = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 64'hDEAD, 64'h55, 5'd0);
      tick();
      n_cmp++; if (wb_data !== 64'h55) begin n_fail++; $display("FAIL wb_sel_alu got=%0h exp=55", wb_data); end
      n_cmp++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL wb_we_rd0 got=%0h exp=0", wb_we); end
      drive(1'b1, 1'b0, 1'b0, 64'd0, 64'h66, 5'd7);
      tick();
      n_cmp++; if (wb_we !== 1'b0 || rd_store !== 5'd7) begin n_fail++; $display("FAIL wb_we_norw got=%0h/%0h exp=0/7", wb_we, rd_store); end
      drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
      tick();
      n_cmp++; if (wb_we !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL wb_we_empty got=%0h/%0h exp=0/0", wb_we, out_valid); end
   endtask

   task automatic test_reset_in_two();
      out_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 64'h77, 64'h88, 5'd8);
      tick();
      drive(1'b1, 1'b1, 1'b0, 64'h99, 64'hAA, 5'd9);
      tick();
      tick();
      n_cmp++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL r2_pre_stall got=%0h exp=5", stall_cnt); end
      reset = 1'b0;
      out_ready = 1'b1;
      tick();
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL r2_handshake got=%0h/%0h exp=0/1", out_valid, in_ready); end
      n_cmp++; if ({RegWrite_store, MemtoReg_store, rd_store} !== 7'd0 || ReadData_store !== 64'd0 || ALU_result_store !== 64'd0) begin n_fail++; $display("FAIL r2_store got=%0h/%0h/%0h exp=0/0/0", {RegWrite_store, MemtoReg_store, rd_store}, ReadData_store, ALU_result_store); end
      n_cmp++; if (stall_cnt !== 16'd0 || stall_cnt2 !== 2'd0) begin n_fail++; $display("FAIL r2_stall got=%0h/%0h exp=0/0", stall_cnt, stall_cnt2); end
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL r2_no_transfer got=%0h exp=0", out_valid); end
   endtask

   task automatic test_saturation();
      out_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 64'd0, 64'h1, 5'd1);
      tick();
      tick();
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k == 3 || k == 4) begin
            n_cmp++; if (stall_cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat_cnt2[%0d] got=%0h exp=3", k, stall_cnt2); end
         end
      end
      n_cmp++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL sat_cnt16 got=%0h exp=5", stall_cnt); end
      n_cmp++; if (stall_cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat_cnt2_final got=%0h exp=3", stall_cnt2); end
      drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_wb_select();
      test_reset_in_two();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of ReadData/ALU_result paths.
REQ-002 SHALL have parameter RD_W, default 5, destination register index width.
REQ-003 SHALL have parameter CNT_W, default 16, stall counter width.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on falling edge of clk.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset, sampled on falling edge of clk.
REQ-006 SHALL have ports in_valid in 1 / in_ready out 1  upstream (MEM) handshake.
REQ-007 SHALL have ports RegWrite, MemtoReg in 1 each; ReadData, ALU_result in DATA_W each; rd in RD_W  upstream payload.
REQ-008 SHALL have port flush  in  1  discard all held entries.
REQ-009 SHALL have ports out_valid out 1 / out_ready in 1  downstream (WB) handshake.
REQ-010 SHALL have ports RegWrite_store, MemtoReg_store out 1; ReadData_store, ALU_result_store out DATA_W; rd_store out RD_W  head-entry payload.
REQ-011 SHALL have port wb_we  out  1  register-file write enable.
REQ-012 SHALL have port wb_data  out  DATA_W  selected writeback data.
REQ-013 SHALL have port stall_cnt  out  CNT_W  upstream stall cycle count.

Function
REQ-014 SHALL hold up to two entries: head (drives *_store outputs) and skid; state EMPTY (0 entries), ONE (head valid), TWO (head+skid valid).
REQ-015 SHALL drive in_ready = (state != TWO), combinational from state only; no combinational path from out_ready to in_ready.
REQ-016 SHALL drive out_valid = (state != EMPTY).
REQ-017 SHALL accept an entry on a falling edge when in_valid && in_ready; complete a transfer when out_valid && out_ready.
REQ-018 EMPTY: accept -> head<=input, ONE; else stay EMPTY.
REQ-019 ONE: accept && transfer -> head<=input, stay ONE; accept && !transfer -> skid<=input, TWO; !accept && transfer -> EMPTY; neither -> hold.
REQ-020 TWO: transfer -> head<=skid, ONE; else hold; no input accepted.
REQ-021 SHALL keep head payload stable while out_valid && !out_ready.
REQ-022 SHALL preserve strict FIFO order; no entry dropped or duplicated outside flush.
REQ-023 flush=1 on a falling edge SHALL force EMPTY; any entry accepted or transferred that edge is discarded; payload registers need not clear.
REQ-024 SHALL drive wb_we = out_valid && RegWrite_store && (rd_store != 0).
REQ-025 SHALL drive wb_data = MemtoReg_store ? ReadData_store : ALU_result_store, combinational.
REQ-026 stall_cnt SHALL increment by 1 on each falling edge with in_valid && !in_ready && !flush; saturates at 2^CNT_W-1; unaffected by flush.
REQ-027 reset low SHALL take priority over flush and all handshakes.

Reset
REQ-028 On reset low at falling edge: state=EMPTY, out_valid=0, in_ready=1 after edge, stall_cnt=0.
REQ-029 On reset: RegWrite_store=0, MemtoReg_store=0, ReadData_store=0, ALU_result_store=0, rd_store=0; hence wb_we=0, wb_data=0.
REQ-030 Reset asserted mid-operation (state TWO) SHALL discard both entries within the same edge; no transfer reported.

Verification
REQ-031 Streaming: out_ready=1, 4 back-to-back inputs (ALU_result=1..4, rd=1..4, MemtoReg=0, RegWrite=1) -> out_valid each following cycle, wb_data 1,2,3,4 in order, in_ready constantly 1, stall_cnt=0.
REQ-032 Backpressure: out_ready=0, push A(ALU_result=0xA), B(0xB), hold in_valid with C -> after 2 edges in_ready=0, head=A, stall_cnt increments each further cycle; release out_ready -> order A,B,C.
REQ-033 Flush in TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, discarded input never appears; stall_cnt unchanged by that edge.
REQ-034 Writeback select: MemtoReg=1, ReadData=0xDEAD, ALU_result=0xBEEF -> wb_data=0xDEAD; rd=0, RegWrite=1 -> wb_we=0.
REQ-035 Reset in TWO with out_ready=1 -> after edge all *_store=0, out_valid=0, stall_cnt=0; CNT_W=2 with 5 stall cycles -> stall_cnt=3 (saturated).
